gray_fifo_ptr_ctrl: RTL and testbench

//  Single-clock FIFO pointer controller for an external 2^ADDR_WIDTH-entry RAM.
//  - Keeps both read and write pointers natively in Gray code, ready for later export across clock domains.
//  - Produces binary RAM addresses, full/empty flags and occupancy by decoding the pointers (gray2bin instances).
//  - Sits between a producer/consumer pair and the shared buffer RAM, and sequences all RAM accesses.

---
 rtl/gray_fifo_ptr_ctrl.sv | 129 ++++++++++++
 tb/tb_gray_fifo_ptr_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/gray_fifo_ptr_ctrl.sv
// Single-clock FIFO pointer controller that keeps read/write pointers in Gray code.
// Optional almost-full/almost-empty flags are enabled by defining GRAY_FIFO_ALMOST_EN.

module gray2bin #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);
  // Each binary bit is the XOR of all Gray bits at or above its position.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin_o[i] = ^(gray_i >> i);
  end
endmodule

module gray_fifo_ptr_ctrl #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  wr_en_i,
  input  logic                  rd_en_i,
`ifdef GRAY_FIFO_ALMOST_EN
  input  logic [ADDR_WIDTH:0]   afull_thr_i,
  input  logic [ADDR_WIDTH:0]   aempty_thr_i,
  output logic                  afull_o,
  output logic                  aempty_o,
`endif
  output logic                  wr_acc_o,
  output logic                  rd_acc_o,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic [ADDR_WIDTH-1:0] raddr_o,
  output logic [ADDR_WIDTH:0]   wgray_o,
  output logic [ADDR_WIDTH:0]   rgray_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  ovf_o,
  output logic                  unf_o
);
  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] wgray_q, wgray_d;
  logic [PW-1:0] rgray_q, rgray_d;
  logic [PW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [PW-1:0] wbin, rbin;
  logic [PW-1:0] wbin_nxt, rbin_nxt;
  logic          wr_acc, rd_acc;
`ifdef GRAY_FIFO_ALMOST_EN
  logic          afull_q, afull_d;
  logic          aempty_q, aempty_d;
`endif

  gray2bin #(.WIDTH(PW)) u_wg2b (.gray_i(wgray_q), .bin_o(wbin));
  gray2bin #(.WIDTH(PW)) u_rg2b (.gray_i(rgray_q), .bin_o(rbin));

  always_comb begin
    wr_acc   = wr_en_i & ~full_q  & ~flush_i;
    rd_acc   = rd_en_i & ~empty_q & ~flush_i;
    wbin_nxt = wbin + PW'(wr_acc);
    rbin_nxt = rbin + PW'(rd_acc);
    if (flush_i) begin
      wbin_nxt = '0;
      rbin_nxt = '0;
    end
    wgray_d = wbin_nxt ^ (wbin_nxt >> 1);
    rgray_d = rbin_nxt ^ (rbin_nxt >> 1);
    // Flags look at the pointers as they will be after this edge.
    empty_d = (wgray_d == rgray_d);
    full_d  = (wgray_d == {~rgray_d[ADDR_WIDTH:ADDR_WIDTH-1], rgray_d[ADDR_WIDTH-2:0]});
    count_d = wbin_nxt - rbin_nxt;
    ovf_d   = wr_en_i & full_q  & ~flush_i;
    unf_d   = rd_en_i & empty_q & ~flush_i;
`ifdef GRAY_FIFO_ALMOST_EN
    afull_d  = (count_d >= afull_thr_i);
    aempty_d = (count_d <= aempty_thr_i);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wgray_q  <= '0;
      rgray_q  <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
`ifdef GRAY_FIFO_ALMOST_EN
      afull_q  <= (afull_thr_i == '0);
      aempty_q <= 1'b1;
`endif
    end else begin
      wgray_q  <= wgray_d;
      rgray_q  <= rgray_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
`ifdef GRAY_FIFO_ALMOST_EN
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
`endif
    end
  end

  assign wr_acc_o = wr_acc;
  assign rd_acc_o = rd_acc;
  assign waddr_o  = wbin[ADDR_WIDTH-1:0];
  assign raddr_o  = rbin[ADDR_WIDTH-1:0];
  assign wgray_o  = wgray_q;
  assign rgray_o  = rgray_q;
  assign full_o   = full_q;
  assign empty_o  = empty_q;
  assign count_o  = count_q;
  assign ovf_o    = ovf_q;
  assign unf_o    = unf_q;
`ifdef GRAY_FIFO_ALMOST_EN
  assign afull_o  = afull_q;
  assign aempty_o = aempty_q;
`endif

endmodule

// File: tb/tb_gray_fifo_ptr_ctrl.sv
// Self-checking bench for gray_fifo_ptr_ctrl (ADDR_WIDTH=4) against an occupancy/pointer-count model.
// Covers the GRAY_FIFO_ALMOST_EN ports when that macro is defined.

module tb_gray_fifo_ptr_ctrl;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int PMASK = 2 * DEPTH - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          wr_acc, rd_acc, full, empty, ovf, unf;
  logic [AW-1:0] waddr, raddr;
  logic [AW:0]   wgray, rgray, count;
`ifdef GRAY_FIFO_ALMOST_EN
  logic [AW:0]   afull_thr = 5'd12;
  logic [AW:0]   aempty_thr = 5'd2;
  logic          afull, aempty;
`endif

  int errors = 0;
  int checks = 0;
  // Model: free-running write/read counts modulo 2*DEPTH
  int m_wp = 0;
  int m_rp = 0;

  gray_fifo_ptr_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .flush_i(flush),
    .wr_en_i(wr_en),
    .rd_en_i(rd_en),
`ifdef GRAY_FIFO_ALMOST_EN
    .afull_thr_i(afull_thr),
    .aempty_thr_i(aempty_thr),
    .afull_o(afull),
    .aempty_o(aempty),
`endif
    .wr_acc_o(wr_acc),
    .rd_acc_o(rd_acc),
    .waddr_o(waddr),
    .raddr_o(raddr),
    .wgray_o(wgray),
    .rgray_o(rgray),
    .full_o(full),
    .empty_o(empty),
    .count_o(count),
    .ovf_o(ovf),
    .unf_o(unf)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int mCount();
    return (m_wp - m_rp) & PMASK;
  endfunction

  function automatic logic [31:0] toGray(input int p);
    return 32'((p ^ (p >> 1)) & PMASK);
  endfunction

  task automatic checkOutput();
    chk("count", count, 32'(mCount()));
    chk("full", full, 32'(mCount() == DEPTH));
    chk("empty", empty, 32'(mCount() == 0));
    chk("wgray", wgray, toGray(m_wp));
    chk("rgray", rgray, toGray(m_rp));
    chk("waddr", waddr, 32'(m_wp % DEPTH));
    chk("raddr", raddr, 32'(m_rp % DEPTH));
`ifdef GRAY_FIFO_ALMOST_EN
    chk("afull", afull, 32'(mCount() >= int'(afull_thr)));
    chk("aempty", aempty, 32'(mCount() <= int'(aempty_thr)));
`endif
  endtask

  task automatic applyStimulus(input bit w, input bit r, input bit f);
    bit          exp_wacc, exp_racc, exp_ovf, exp_unf;
    logic [AW:0] prev_wg, prev_rg;
    int          cnt;
    @(negedge clk);
    wr_en = w;
    rd_en = r;
    flush = f;
    #1;
    cnt      = mCount();
    exp_wacc = w && (cnt != DEPTH) && !f;
    exp_racc = r && (cnt != 0) && !f;
    exp_ovf  = w && (cnt == DEPTH) && !f;
    exp_unf  = r && (cnt == 0) && !f;
    chk("wr_acc", wr_acc, 32'(exp_wacc));
    chk("rd_acc", rd_acc, 32'(exp_racc));
    prev_wg = wgray;
    prev_rg = rgray;
    @(posedge clk);
    #1;
    if (f) begin
      m_wp = 0;
      m_rp = 0;
    end else begin
      m_wp = (m_wp + int'(exp_wacc)) & PMASK;
      m_rp = (m_rp + int'(exp_racc)) & PMASK;
      chk("wgray_onebit", 32'($countones(wgray ^ prev_wg) <= 1), 32'd1);
      chk("rgray_onebit", 32'($countones(rgray ^ prev_rg) <= 1), 32'd1);
    end
    chk("ovf", ovf, 32'(exp_ovf));
    chk("unf", unf, 32'(exp_unf));
    checkOutput();
  endtask

  initial begin
    // Reset held for two edges
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", empty, 32'd1);
    chk("rst_full", full, 32'd0);
    chk("rst_count", count, 32'd0);
    chk("rst_wgray", wgray, 32'h00);
    chk("rst_rgray", rgray, 32'h00);
    chk("rst_ovf", ovf, 32'd0);
    chk("rst_unf", unf, 32'd0);
    checkOutput();
    @(negedge clk);
    rst = 1'b0;

    // Fill to full
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    chk("fill_full", full, 32'd1);
    chk("fill_count", count, 32'd16);
    chk("fill_wgray", wgray, 32'h18);
    chk("fill_waddr", waddr, 32'd0);

    // Overflow attempt, then simultaneous rd+wr while full
    applyStimulus(1'b1, 1'b0, 1'b0);
    chk("ovf_pulse", ovf, 32'd1);
    chk("ovf_wgray", wgray, 32'h18);
    applyStimulus(1'b1, 1'b1, 1'b0);
    chk("fullrw_count", count, 32'd15);
    chk("fullrw_full", full, 32'd0);
    chk("fullrw_ovf", ovf, 32'd1);

    // Drain, underflow, simultaneous rd+wr while empty
    for (int i = 0; i < DEPTH - 1; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    chk("drain_empty", empty, 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    chk("unf_pulse", unf, 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    chk("emptyrw_unf", unf, 32'd1);
    chk("emptyrw_count", count, 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0);

    // Interleaved write/read pairs carry both pointers through the wrap
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      chk("wrap_count_w", 32'(count <= 5'd1), 32'd1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      chk("wrap_count_r", 32'(count <= 5'd1), 32'd1);
    end

    // Random traffic with occasional flushes
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 40) == 0));
    end

    // Flush from count 9 with a concurrent write request
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    chk("preflush_count", count, 32'd9);
    applyStimulus(1'b1, 1'b0, 1'b1);
    chk("flush_count", count, 32'd0);
    chk("flush_empty", empty, 32'd1);
    chk("flush_ovf", ovf, 32'd0);

`ifdef GRAY_FIFO_ALMOST_EN
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    chk("afull_set", afull, 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    chk("afull_clr", afull, 32'd0);
`endif

    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    flush = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
